// File: rtl/alu_seq_pkg.sv
// Shared types for the word-serial ALU sequencer: opcodes, FSM states and word-order helpers.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SHR = 3'b001,
    ALU_SHL = 3'b010,
    ALU_NOT = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_CMP = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } alu_seq_state_e;

  // Right shift and compare resolve from the top word down.
  function automatic logic is_msb_first(input alu_op_e op);
    return (op == ALU_SHR) || (op == ALU_CMP);
  endfunction

  function automatic logic has_carry(input alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SHR) || (op == ALU_SHL);
  endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational N-bit ALU slice with carry in/out and word compare flags.
module alu
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  alu_op_e        op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           carry_in,
  output logic [N-1:0]   c,
  output logic           carry_out,
  output logic           a_eq_b,
  output logic           a_gt_b
);

  logic [N:0] sum;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carry_in};
    c         = '0;
    carry_out = 1'b0;
    case (op)
      ALU_ADD: begin
        c         = sum[N-1:0];
        carry_out = sum[N];
      end
      ALU_SHR: begin
        c         = {carry_in, a[N-1:1]};
        carry_out = a[0];
      end
      ALU_SHL: begin
        c         = {a[N-2:0], carry_in};
        carry_out = a[N-1];
      end
      ALU_NOT: c = ~a;
      ALU_AND: c = a & b;
      ALU_OR:  c = a | b;
      ALU_XOR: c = a ^ b;
      default: c = '0;
    endcase
  end

  assign a_eq_b = (a == b);
  assign a_gt_b = (a > b);

endmodule

// File: rtl/alu_seq.sv
// Word-serial W-bit ALU: one N-bit word per cycle through a single alu slice.
// Build option ALU_SEQ_EARLY_EXIT_EN lets CMP finish at the first differing word.
//
// state   | meaning
// ST_IDLE | waiting for a request, req_ready high
// ST_RUN  | stepping one word per cycle through the slice
// ST_DONE | result held, rsp_valid high until consumed
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [N*WORDS-1:0] req_a,
  input  logic [N*WORDS-1:0] req_b,
  input  logic               req_carry_in,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N*WORDS-1:0] rsp_c,
  output logic               rsp_carry_out,
  output logic               rsp_gt,
  output logic               rsp_eq,
  output logic               rsp_zero
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  alu_seq_state_e state;
  alu_op_e        op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [IW-1:0]  idx;
  logic           cy;

  logic [N-1:0]   a_w;
  logic [N-1:0]   b_w;
  logic [N-1:0]   c_w;
  logic           co_w;
  logic           eq_w;
  logic           gt_w;
  logic           msb_first;
  logic           last_word;
  logic           done_now;

  always_comb begin
    a_w = a_q[idx*N +: N];
    b_w = b_q[idx*N +: N];
  end

  alu #(.N(N)) u_alu (
    .op        (op_q),
    .a         (a_w),
    .b         (b_w),
    .carry_in  (cy),
    .c         (c_w),
    .carry_out (co_w),
    .a_eq_b    (eq_w),
    .a_gt_b    (gt_w)
  );

  assign msb_first = is_msb_first(op_q);
  assign last_word = msb_first ? (idx == '0) : (idx == LAST_IDX);

`ifdef ALU_SEQ_EARLY_EXIT_EN
  // Once a word differs the remaining words cannot change gt or eq.
  assign done_now = last_word || ((op_q == ALU_CMP) && !eq_w);
`else
  assign done_now = last_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_c         <= '0;
      rsp_carry_out <= 1'b0;
      rsp_gt        <= 1'b0;
      rsp_eq        <= 1'b0;
      rsp_zero      <= 1'b0;
      op_q          <= ALU_ADD;
      a_q           <= '0;
      b_q           <= '0;
      idx           <= '0;
      cy            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_q          <= alu_op_e'(req_op);
            a_q           <= req_a;
            b_q           <= req_b;
            cy            <= req_carry_in;
            idx           <= is_msb_first(alu_op_e'(req_op)) ? LAST_IDX : '0;
            rsp_c         <= '0;
            rsp_carry_out <= 1'b0;
            rsp_gt        <= 1'b0;
            rsp_eq        <= 1'b1;
            rsp_zero      <= 1'b1;
            req_ready     <= 1'b0;
            state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          rsp_c[idx*N +: N] <= c_w;
          cy                <= co_w;
          rsp_eq            <= rsp_eq & eq_w;
          rsp_gt            <= msb_first ? (rsp_gt | (rsp_eq & gt_w))
                                         : (gt_w | (eq_w & rsp_gt));
          rsp_zero          <= rsp_zero & (c_w == '0);
          idx               <= msb_first ? (idx - 1'b1) : (idx + 1'b1);
          if (done_now) begin
            rsp_carry_out <= has_carry(op_q) & co_w;
            rsp_valid     <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=8, WORDS=4) against a whole-operand arithmetic model.
module tb_alu_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_carry_in;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_c;
  logic         rsp_carry_out;
  logic         rsp_gt;
  logic         rsp_eq;
  logic         rsp_zero;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  alu_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_carry_in  (req_carry_in),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_c         (rsp_c),
    .rsp_carry_out (rsp_carry_out),
    .rsp_gt        (rsp_gt),
    .rsp_eq        (rsp_eq),
    .rsp_zero      (rsp_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-operand arithmetic, independent of word slicing.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, output logic [W-1:0] c, output logic [3:0] flg,
                       output int lat);
    logic [W:0] s;
    logic       co;
    logic       found;
    s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    co = 1'b0;
    case (op)
      3'd0: begin c = s[W-1:0]; co = s[W]; end
      3'd1: begin c = {ci, a[W-1:1]}; co = a[0]; end
      3'd2: begin c = {a[W-2:0], ci}; co = a[W-1]; end
      3'd3: c = ~a;
      3'd4: c = a & b;
      3'd5: c = a | b;
      3'd6: c = a ^ b;
      default: c = '0;
    endcase
    flg = {co, (a > b), (a == b), (c == '0)};
    lat = WORDS;
`ifdef ALU_SEQ_EARLY_EXIT_EN
    if (op == 3'd7) begin
      found = 1'b0;
      for (int k = 0; k < WORDS; k++) begin
        if (!found && (a[(WORDS-1-k)*N +: N] != b[(WORDS-1-k)*N +: N])) begin
          found = 1'b1;
          lat   = k + 1;
        end
      end
    end
`else
    found = 1'b0;
`endif
  endtask

  // Starts and finishes just after a falling edge.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input int hold);
    logic [W-1:0] ec;
    logic [3:0]   ef;
    int           elat;
    int           lat;
    model(op, a, b, ci, ec, ef, elat);
    chk("req_ready_idle", req_ready, 1);
    req_valid    = 1'b1;
    req_op       = op;
    req_a        = a;
    req_b        = b;
    req_carry_in = ci;
    @(negedge clk);
    req_valid    = 1'b0;
    req_op       = 3'($urandom);
    req_a        = $urandom;
    req_b        = $urandom;
    req_carry_in = 1'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, elat);
    chk("rsp_c", rsp_c, ec);
    chk("flags_co_gt_eq_z", {rsp_carry_out, rsp_gt, rsp_eq, rsp_zero}, ef);
    chk("req_ready_busy", req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_c", rsp_c, ec);
      chk("hold_flags", {rsp_carry_out, rsp_gt, rsp_eq, rsp_zero}, ef);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("valid_after_hs", rsp_valid, 0);
    chk("ready_after_hs", req_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] mask;
    int           mode;
    int           seen;

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_op       = '0;
    req_a        = '0;
    req_b        = '0;
    req_carry_in = 1'b0;
    rsp_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outputs", {rsp_valid, rsp_c, rsp_carry_out, rsp_gt, rsp_eq, rsp_zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    do_op(3'd1, 32'h8000_0001, 32'h0000_0000, 1'b1, 0);
    do_op(3'd2, 32'h8000_0001, 32'h0000_0000, 1'b0, 0);
    do_op(3'd7, 32'h0100_0000, 32'h00FF_FFFF, 1'b0, 0);
    do_op(3'd7, 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    do_op(3'd0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 3);

    // Reset mid-RUN must drop the operation without a response.
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 32'h0F0F_0F0F;
    req_b     = 32'h0101_0101;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_req_ready", req_ready, 1);
    chk("midrun_rst_outputs", {rsp_valid, rsp_c, rsp_carry_out, rsp_gt, rsp_eq, rsp_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_rst", seen, 0);
    do_op(3'd6, 32'hA5A5_5A5A, 32'hFFFF_0000, 1'b0, 1);

    for (int t = 0; t < 48; t++) begin
      ra   = $urandom;
      rb   = $urandom;
      mode = $urandom_range(0, 2);
      if (mode == 1) rb = ra;
      if (mode == 2) begin
        mask = {W{1'b1}} << (N * $urandom_range(1, WORDS - 1));
        rb   = (ra & mask) | (rb & ~mask);
      end
      do_op(3'($urandom_range(0, 7)), ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter N, default 8: ALU word width in bits.
REQ-002 SHALL have parameter WORDS, default 4: words per operand; operand width W = N*WORDS.
REQ-003 SHALL have port clk  input  1  the single clock; all state rises on its positive edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high on a clk edge.
REQ-007 SHALL have port req_op  input  3  ALU opcode: 000 ADD, 001 SHR, 010 SHL, 011 NOT, 100 AND, 101 OR, 110 XOR, 111 CMP.
REQ-008 SHALL have ports req_a, req_b  input  W  operands.
REQ-009 SHALL have port req_carry_in  input  1  carry into the operation.
REQ-010 SHALL have port rsp_valid  output  1  result present.
REQ-011 SHALL have port rsp_ready  input  1  result consumed on a clk edge where rsp_valid and rsp_ready are both high.
REQ-012 SHALL have port rsp_c  output  W  result.
REQ-013 SHALL have ports rsp_carry_out, rsp_gt, rsp_eq, rsp_zero  output  1 each  whole-operand flags.

Function
REQ-014 SHALL run a 3-state FSM: IDLE -> RUN on request acceptance; RUN -> DONE after the last word; DONE -> IDLE on response handshake.
REQ-015 SHALL assert req_ready only in IDLE and rsp_valid only in DONE; the block holds one operation at a time.
REQ-016 SHALL latch req_op, req_a, req_b and req_carry_in on acceptance; later changes to req_* have no effect.
REQ-017 SHALL process one N-bit word per cycle through one alu instance, so rsp_valid rises exactly WORDS cycles after the acceptance edge.
REQ-018 SHALL process words in this order:
- LSB-first: ADD, SHL, NOT, AND, OR, XOR.
- MSB-first: SHR, CMP.
REQ-019 SHALL chain carries between words:
- The first word's carry_in is req_carry_in.
- Each subsequent word's carry_in is the previous word's carry_out.
- rsp_carry_out is the final word's carry_out.
REQ-020 SHALL compute rsp_eq as the AND of per-word a_eq_b.
REQ-021 SHALL compute rsp_gt with the update rule matching the word order:
- LSB-first: gt := gt_w | (eq_w & gt).
- MSB-first: gt := gt | (eq & gt_w).
- Result is the unsigned W-bit comparison a > b.
REQ-022 SHALL set rsp_zero high iff every result word is zero; for CMP, rsp_c is 0 and rsp_zero is 1.
REQ-023 SHALL force rsp_carry_out to 0 for NOT, AND, OR, XOR and CMP.
REQ-024 SHALL hold rsp_c and all flags stable while rsp_valid is high and rsp_ready is low.
REQ-025 SHALL deassert rsp_valid on the handshake edge and assert req_ready in the following cycle; a request and a response never complete on the same edge.

Reset
REQ-026 SHALL on rst_n low immediately force:
- FSM to IDLE;
- req_ready to 1 and rsp_valid to 0;
- rsp_c and every flag to 0.
REQ-027 SHALL discard any in-flight operation on reset, including one in RUN or DONE; no response is produced for it.

Configuration
REQ-028 SHALL honour macro ALU_SEQ_EARLY_EXIT_EN, which affects CMP only:
- Defined: CMP enters DONE after the first MSB-first word whose a_eq_b is 0, giving latency 1..WORDS cycles.
- Undefined: every operation has a fixed latency of WORDS cycles.
- Flag values are identical in both builds.

Structure
REQ-029 SHALL place in shared package alu_seq_pkg: the opcode enum (ALU_ADD, ALU_SHR, ALU_SHL, ALU_NOT, ALU_AND, ALU_OR, ALU_XOR, ALU_CMP) and the FSM state enum.
REQ-030 SHALL instantiate exactly one existing alu sub-module with parameter N; the word index counter is ceil(log2(WORDS)) bits wide.

Verification (N=8, WORDS=4)
REQ-031 SHALL verify:
- Stimulus: ADD 0x000000FF + 0x00000001, carry_in 0.
- Response: rsp_c 0x00000100, carry_out 0, gt 1, eq 0, zero 0.
- Timing: rsp_valid exactly 4 cycles after acceptance.
REQ-032 SHALL verify:
- Stimulus: ADD 0xFFFFFFFF + 0x00000001, carry_in 0.
- Response: rsp_c 0, carry_out 1, zero 1, gt 1.
REQ-033 SHALL verify:
- Stimulus: SHR a=0x80000001, carry_in 1 -> rsp_c 0xC0000000, carry_out 1.
- Stimulus: SHL a=0x80000001, carry_in 0 -> rsp_c 0x00000002, carry_out 1.
REQ-034 SHALL verify:
- Stimulus: CMP a=0x01000000, b=0x00FFFFFF.
- Response: rsp_c 0, gt 1, eq 0, zero 1.
- Timing: rsp_valid after 1 cycle with ALU_SEQ_EARLY_EXIT_EN, after 4 cycles without.
- Also: CMP a=b=0x12345678 -> eq 1, gt 0, latency 4 in both builds.
REQ-035 SHALL verify:
- Backpressure: hold rsp_ready low for 3 cycles -> outputs stable and req_ready low throughout.
- Reset: pulse rst_n low mid-RUN -> IDLE with all outputs 0, and the next request completes correctly.
